dmem_arbiter: RTL and testbench

Two-port arbiter for the 8-bit data memory of the jacaranda-8 computer. It shares the single-port `data_mem` between the CPU load/store path and a Wishbone-side host port. The host port lets the management core preload or inspect data memory while the CPU runs. The CPU has priority with zero added latency; a starvation counter guarantees the host port a slot within a bounded number of cycles. The block sits between `cpu`/MMIO decode and `data_mem`.

---
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and a host port.
// The CPU wins by default; the host is forced a slot after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
   parameter int unsigned       ADDR_W       = 8,
   parameter int unsigned       DATA_W       = 8,
   parameter logic [ADDR_W-1:0] MMIO_BASE    = 8'd249,
   parameter int unsigned       STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e              state_q;
   logic [3:0]          starve_cnt_q;
   logic                host_ack_q;
   logic                host_err_q;
   logic [DATA_W-1:0]   host_rdata_q;

   logic host_in_range;
   logic host_elig;
   logic host_grant;
   logic cpu_grant;

   always_comb begin
      host_in_range = host_addr < MMIO_BASE;
      // Host is held off while reset is asserted so no host write can slip out during reset.
      host_elig     = reset_n && (state_q == StIdle) && host_req;
      host_grant    = host_elig && ((starve_cnt_q == StarveMax) || !cpu_req);
      cpu_grant     = cpu_req && !host_grant;
      cpu_stall     = cpu_req && host_grant;
      cpu_rdata     = mem_rdata;
      if (host_grant) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_we    = host_we && host_in_range;
      end else begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_grant && cpu_we;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         starve_cnt_q <= '0;
         host_ack_q   <= 1'b0;
         host_err_q   <= 1'b0;
         host_rdata_q <= '0;
      end else begin
         state_q    <= host_grant ? StAck : StIdle;
         host_ack_q <= host_grant;
         host_err_q <= host_grant && !host_in_range;
         if (host_grant && host_in_range) begin
            host_rdata_q <= mem_rdata;
         end else begin
            host_rdata_q <= '0;
         end
         if (!host_req || host_grant) begin
            starve_cnt_q <= '0;
         end else if (host_elig && cpu_grant && (starve_cnt_q != StarveMax)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
         end
      end
   end

   assign host_ack   = host_ack_q;
   assign host_err   = host_err_q;
   assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: a spec-level model predicts per-cycle behaviour and
// host responses into queues; a negedge monitor pops and compares against the DUT.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;
   localparam logic [7:0]  MMIO  = 8'd249;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       cpu_req = 1'b0, cpu_we = 1'b0;
   logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
   logic [7:0] cpu_rdata;
   logic       cpu_stall;
   logic       host_req = 1'b0, host_we = 1'b0;
   logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
   logic       host_ack, host_err;
   logic [7:0] host_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we;

   always #5 clock = ~clock;

   dmem_arbiter #(
      .ADDR_W(8), .DATA_W(8), .MMIO_BASE(MMIO), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .host_err(host_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   // Environment: the data_mem itself (combinational read, write at rising edge).
   logic [7:0] dmem [256] = '{default: 8'h00};
   assign mem_rdata = dmem[mem_addr];
   always @(posedge clock) if (mem_we) dmem[mem_addr] <= mem_wdata;

   typedef struct packed {
      logic       ack;
      logic       stall;
      logic       we;
      logic       chk_rd;
      logic [7:0] rd;
   } cyc_t;
   typedef struct packed {
      logic       err;
      logic [7:0] rd;
   } host_t;

   cyc_t  cyc_q [$];
   host_t host_q [$];

   // Reference model state: what memory should hold, and the host's arbitration history.
   logic [7:0] ref_mem [256] = '{default: 8'h00};
   logic       m_in_ack = 1'b0;
   int         m_denied = 0;
   logic       last_host_gets = 1'b0;
   logic       last_stall = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   function automatic void check(input string name, input logic [7:0] act,
                                 input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // One clock cycle of stimulus plus the model's prediction for it.
   task automatic step(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                       input logic [7:0] c_wdata, input logic h_req, input logic h_we,
                       input logic [7:0] h_addr, input logic [7:0] h_wdata);
      cyc_t  e;
      host_t h;
      logic  host_gets, cpu_gets, in_range;
      @(posedge clock);
      #2;
      cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
      host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
      in_range  = h_addr < MMIO;
      host_gets = h_req && !m_in_ack && (m_denied >= int'(LIMIT) || !c_req);
      cpu_gets  = c_req && !host_gets;
      e.ack     = m_in_ack;
      e.stall   = c_req && !cpu_gets;
      e.we      = host_gets ? (h_we && in_range) : (cpu_gets && c_we);
      e.chk_rd  = cpu_gets && !c_we;
      e.rd      = ref_mem[c_addr];
      if (host_gets) begin
         h.err = !in_range;
         h.rd  = in_range ? ref_mem[h_addr] : 8'h00;
         host_q.push_back(h);
         if (h_we && in_range) ref_mem[h_addr] = h_wdata;
      end
      if (cpu_gets && c_we) ref_mem[c_addr] = c_wdata;
      if (!h_req || host_gets) m_denied = 0;
      else if (!m_in_ack && cpu_gets && m_denied < int'(LIMIT)) m_denied++;
      m_in_ack       = host_gets;
      last_host_gets = host_gets;
      last_stall     = e.stall;
      cyc_q.push_back(e);
   endtask

   task automatic host_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic cpu_busy, input logic [7:0] c_addr);
      int n = 0;
      do begin
         step(cpu_busy, 1'b0, c_addr, 8'h00, 1'b1, we, addr, wdata);
         n++;
      end while (!last_host_gets && n < 20);
      step(cpu_busy, 1'b0, c_addr, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   function automatic logic [7:0] rand_addr();
      if ($urandom_range(15) == 0) return 8'(245 + $urandom_range(10));
      return 8'($urandom_range(31));
   endfunction

   // Monitor: mid-cycle, away from the rising edge.
   cyc_t  mon_e;
   host_t mon_h;
   always @(negedge clock) begin
      if (cyc_q.size() != 0) begin
         mon_e = cyc_q.pop_front();
         check("cpu_stall", 8'(cpu_stall), 8'(mon_e.stall));
         check("mem_we", 8'(mem_we), 8'(mon_e.we));
         check("host_ack", 8'(host_ack), 8'(mon_e.ack));
         if (mon_e.chk_rd) check("cpu_rdata", cpu_rdata, mon_e.rd);
         if (host_ack) begin
            if (host_q.size() == 0) begin
               check("host_ack_unexpected", 8'(host_ack), 8'h00);
            end else begin
               mon_h = host_q.pop_front();
               check("host_err", 8'(host_err), 8'(mon_h.err));
               check("host_rdata", host_rdata, mon_h.rd);
            end
         end else begin
            check("host_err_idle", 8'(host_err), 8'h00);
            check("host_rdata_idle", host_rdata, 8'h00);
         end
      end
   end

   initial begin
      cyc_t       e0;
      logic       h_req, h_we, ack_phase;
      logic [7:0] h_addr, h_wdata;
      logic       c_req, c_we;
      logic [7:0] c_addr, c_wdata;

      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;

      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // Host alone: write then read back.
      host_txn(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
      host_txn(1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
      // Starvation under continuous CPU reads.
      host_txn(1'b1, 8'h11, 8'h5A, 1'b1, 8'h10);
      host_txn(1'b0, 8'h11, 8'h00, 1'b1, 8'h11);
      // Back-to-back: request held through the ACK cycle.
      repeat (4) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // MMIO boundary.
      host_txn(1'b1, 8'hFB, 8'h11, 1'b0, 8'h00);
      host_txn(1'b1, 8'hF9, 8'h22, 1'b0, 8'h00);
      host_txn(1'b1, 8'hF8, 8'h33, 1'b0, 8'h00);
      host_txn(1'b0, 8'hF8, 8'h00, 1'b0, 8'h00);
      // CPU transparency.
      step(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // Random traffic.
      h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00; ack_phase = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
      for (int i = 0; i < 1500; i++) begin
         if (ack_phase) begin
            ack_phase = 1'b0;
            if ($urandom_range(1) == 0) h_req = 1'b0;
         end else if (!h_req) begin
            if ($urandom_range(3) == 0) begin
               h_req = 1'b1; h_we = 1'($urandom_range(1));
               h_addr = rand_addr(); h_wdata = 8'($urandom);
            end
         end else if ($urandom_range(9) == 0) begin
            h_addr = rand_addr(); h_wdata = 8'($urandom);
         end
         if (!last_stall) begin
            c_req = ($urandom_range(9) < 7); c_we = 1'($urandom_range(1));
            c_addr = 8'($urandom_range(31)); c_wdata = 8'($urandom);
         end
         step(c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata);
         if (last_host_gets) ack_phase = 1'b1;
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset asserted in the grant cycle of a host write: no write, no ack.
      e0 = '{ack: 1'b0, stall: 1'b0, we: 1'b0, chk_rd: 1'b0, rd: 8'h00};
      @(posedge clock);
      #2;
      cpu_req = 1'b0; cpu_we = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
      cyc_q.push_back(e0);
      #1 reset_n = 1'b0;
      @(posedge clock);
      #2;
      host_req = 1'b0; host_we = 1'b0;
      cyc_q.push_back(e0);
      m_in_ack = 1'b0; m_denied = 0; last_stall = 1'b0; last_host_gets = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b1;
      host_txn(1'b0, 8'h30, 8'h00, 1'b0, 8'h00);
      host_txn(1'b1, 8'h31, 8'h9C, 1'b1, 8'h30);
      host_txn(1'b0, 8'h31, 8'h00, 1'b1, 8'h31);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      @(negedge clock);
      #1;
      check("host_q_drained", 8'(host_q.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
